// File: rtl/rc4_key_schedule_if.sv
// Control and S RAM bus between the key-search controller, the S RAM and the RC4 key schedule.
// The master modport is the key-schedule side; the slave modport is the controller/RAM side.
`timescale 1ns/1ps
interface rc4_key_schedule_if #(
  parameter int unsigned KEY_BYTES = 3
);
  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic [7:0]             mem_rdata;
  logic [7:0]             mem_addr;
  logic [7:0]             mem_wdata;
  logic                   mem_wren;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, secret_key, mem_rdata,
    output mem_addr, mem_wdata, mem_wren, busy, done
  );

  modport slave (
    output start, secret_key, mem_rdata,
    input  mem_addr, mem_wdata, mem_wren, busy, done
  );
endinterface

// File: rtl/rc4_key_schedule.sv
// RC4 key-scheduling algorithm over a single-port 256-byte S RAM with one-cycle read latency.
// Initialises S to identity, runs the key-driven swap loop, then holds done until the next start.
`timescale 1ns/1ps
module rc4_key_schedule #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned S_DEP     = 256
) (
  input logic               clk,
  input logic               reset_n,
  rc4_key_schedule_if.master bus
);

  localparam int unsigned KeyIdxW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [7:0]         LastIdx = 8'(S_DEP - 1);
  localparam logic [KeyIdxW-1:0] LastKey = KeyIdxW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StInit,
    StRdI,
    StLatI,
    StRdJ,
    StLatJ,
    StWrI,
    StWrJ,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          i_q, i_d;
  logic [7:0]          j_q, j_d;
  logic [7:0]          si_q, si_d;
  logic [7:0]          sj_q, sj_d;
  logic [KeyIdxW-1:0]  kidx_q, kidx_d;
  logic [KEY_BYTES-1:0][7:0] key_bytes;
  logic [7:0]          key_byte;

  // Key byte 0 is the MSB byte, so the key index counts down from the top byte and wraps.
  assign key_bytes = bus.secret_key;
  assign key_byte  = key_bytes[kidx_q];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      si_q    <= 8'h00;
      sj_q    <= 8'h00;
      kidx_q  <= LastKey;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    si_d          = si_q;
    sj_d          = sj_q;
    kidx_d        = kidx_q;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    bus.mem_wren  = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.busy = 1'b0;
        i_d      = 8'h00;
        j_d      = 8'h00;
        kidx_d   = LastKey;
        if (bus.start) begin
          state_d = StInit;
        end
      end
      StInit: begin
        bus.mem_addr  = i_q;
        bus.mem_wdata = i_q;
        bus.mem_wren  = 1'b1;
        i_d           = i_q + 8'd1;
        if (i_q == LastIdx) begin
          i_d     = 8'h00;
          j_d     = 8'h00;
          kidx_d  = LastKey;
          state_d = StRdI;
        end
      end
      StRdI: begin
        bus.mem_addr = i_q;
        state_d      = StLatI;
      end
      StLatI: begin
        si_d    = bus.mem_rdata;
        j_d     = j_q + bus.mem_rdata + key_byte;
        state_d = StRdJ;
      end
      StRdJ: begin
        bus.mem_addr = j_q;
        state_d      = StLatJ;
      end
      StLatJ: begin
        sj_d    = bus.mem_rdata;
        state_d = StWrI;
      end
      StWrI: begin
        bus.mem_addr  = i_q;
        bus.mem_wdata = sj_q;
        bus.mem_wren  = 1'b1;
        state_d       = StWrJ;
      end
      StWrJ: begin
        bus.mem_addr  = j_q;
        bus.mem_wdata = si_q;
        bus.mem_wren  = 1'b1;
        if (i_q == LastIdx) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == '0) ? LastKey : kidx_q - 1'b1;
          state_d = StRdI;
        end
      end
      StDone: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
        if (bus.start) begin
          i_d     = 8'h00;
          j_d     = 8'h00;
          kidx_d  = LastKey;
          state_d = StInit;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_key_schedule.sv
// Directed bench for rc4_key_schedule: behavioural S RAM, write-trace timing checks and a
// reference RC4 KSA model for final-contents comparison.
`timescale 1ns/1ps
module tb_rc4_key_schedule;

  logic clk = 1'b0;
  logic reset_n;

  rc4_key_schedule_if #(.KEY_BYTES(3)) bus ();

  rc4_key_schedule #(.KEY_BYTES(3), .S_DEP(256)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with one-cycle read latency.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int wr_cnt    = 0;
  int trace_err = 0;
  int wren_bad  = 0;
  int done_cyc  = -1;
  int n_before;
  logic [7:0] wa [1024];
  logic [7:0] wd [1024];
  logic [7:0] exp_s [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge and record the write trace.
  task automatic step();
    int exp_c;
    @(negedge clk);
    cyc++;
    if (bus.mem_wren === 1'b1) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) wren_bad++;
      if (wr_cnt < 256) exp_c = wr_cnt + 1;
      else exp_c = 261 + 6 * ((wr_cnt - 256) / 2) + ((wr_cnt - 256) % 2);
      if (cyc != exp_c) trace_err++;
      if (wr_cnt < 256 && (bus.mem_addr !== 8'(wr_cnt) || bus.mem_wdata !== 8'(wr_cnt)))
        trace_err++;
      if (wr_cnt < 1024) begin
        wa[wr_cnt] = bus.mem_addr;
        wd[wr_cnt] = bus.mem_wdata;
      end
      wr_cnt++;
    end
    if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic begin_run(input logic [23:0] key);
    bus.secret_key = key;
    bus.start      = 1'b1;
    cyc            = 0;
    wr_cnt         = 0;
    trace_err      = 0;
    done_cyc       = -1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_key(input string tag, input logic [23:0] key, input bit glitch);
    begin_run(key);
    check({tag, "_done_c1"}, bus.done, 0);
    check({tag, "_busy_c1"}, bus.busy, 1);
    while (done_cyc < 0 && cyc < 2000) begin
      bus.start = glitch && (cyc == 99 || cyc == 999 || cyc == 1500);
      step();
    end
    bus.start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, 1793);
    check({tag, "_write_count"}, wr_cnt, 768);
    check({tag, "_trace_errors"}, trace_err, 0);
  endtask

  task automatic model(input logic [23:0] key);
    int j;
    logic [7:0] kb, t;
    for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j = (j + int'(exp_s[i]) + int'(kb)) % 256;
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic check_ram(input string tag, input logic [23:0] key);
    int err;
    logic [255:0] seen;
    model(key);
    err = 0;
    seen = '0;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== exp_s[i]) err++;
      if (!$isunknown(ram[i])) seen[ram[i]] = 1'b1;
    end
    check({tag, "_ram_vs_model"}, err, 0);
    check({tag, "_permutation"}, {31'b0, &seen}, 1);
  endtask

  task automatic check_wr(input string tag, input int n, input int a, input int d);
    check({tag, "_addr"}, wa[n], a);
    check({tag, "_data"}, wd[n], d);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.secret_key = 24'h000000;
    repeat (3) step();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wren", bus.mem_wren, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    reset_n = 1'b1;
    repeat (2) step();
    check("idle_wren", bus.mem_wren, 0);

    // Zero key from IDLE, with start pulses while busy.
    run_key("k0", 24'h000000, 1'b1);
    check_wr("k0_i0_wri", 256, 8'h00, 8'h00);
    check_wr("k0_i0_wrj", 257, 8'h00, 8'h00);
    check_wr("k0_i1_wri", 258, 8'h01, 8'h01);
    check_wr("k0_i1_wrj", 259, 8'h01, 8'h01);
    check_wr("k0_i2_wri", 260, 8'h02, 8'h03);
    check_wr("k0_i2_wrj", 261, 8'h03, 8'h02);
    check_ram("k0", 24'h000000);
    step();
    check("k0_done_hold", bus.done, 1);

    // Restart from DONE with a new key.
    run_key("k249", 24'h000249, 1'b0);
    check_wr("k249_i1_wri", 258, 8'h01, 8'h03);
    check_wr("k249_i1_wrj", 259, 8'h03, 8'h01);
    check_ram("k249", 24'h000249);

    // All-ones key: j sums wrap modulo 256.
    run_key("kff", 24'hFFFFFF, 1'b0);
    check_wr("kff_i0_wri", 256, 8'h00, 8'hFF);
    check_wr("kff_i0_wrj", 257, 8'hFF, 8'h00);
    check_wr("kff_i1_wri", 258, 8'h01, 8'h00);
    check_wr("kff_i1_wrj", 259, 8'hFF, 8'h01);
    check_ram("kff", 24'hFFFFFF);

    // Reset in the middle of the swap loop.
    begin_run(24'h123456);
    while (cyc < 600) step();
    reset_n = 1'b0;
    step();
    check("midrst_busy", bus.busy, 0);
    check("midrst_wren", bus.mem_wren, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_addr", bus.mem_addr, 0);
    check("midrst_wdata", bus.mem_wdata, 0);
    n_before = wr_cnt;
    repeat (4) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("midrst_no_writes", wr_cnt, n_before);
    check("midrst_idle_done", bus.done, 0);

    run_key("k5a", 24'h5A13C7, 1'b1);
    check_ram("k5a", 24'h5A13C7);

    check("wren_protocol", wren_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc4_key_schedule.md
# rc4_key_schedule

Upstream stage of the RC4 decryption datapath. It runs the RC4 key-scheduling algorithm on the 256-byte S working memory. First it initialises S[i] = i. Then it performs the key-driven swap loop using a 24-bit secret key. It owns the single-port S RAM while busy and hands a fully permuted S to the decryption FSM, signalled by `done`. The key-search controller pulses `start` once per candidate key.

## Interface

Parameters:
- `KEY_BYTES`, default 3: secret key length in bytes. Key byte k is `secret_key[8*(KEY_BYTES-k)-1 -: 8]`, so byte 0 is the MSB byte.
- `S_DEP`, default 256: S memory depth. Fixed at 256.

Ports:
- `clk`: input, 1 bit. The single clock.
- `reset_n`: input, 1 bit. Synchronous, active-low reset.
- `start`: input, 1 bit. Level-sampled in IDLE or DONE. Begins a schedule.
- `secret_key`: input, 8*KEY_BYTES bits. Must be held stable from the `start` sample until `done`.
- `mem_rdata`: input, 8 bits. S RAM read data. Valid in the cycle after its address is presented.
- `mem_addr`: output, 8 bits. S RAM address.
- `mem_wdata`: output, 8 bits. S RAM write data.
- `mem_wren`: output, 1 bit. S RAM write enable.
- `busy`: output, 1 bit. High in every state except IDLE and DONE.
- `done`: output, 1 bit. High only in DONE.

## Operation

- State machine states: IDLE, INIT, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE.
- IDLE: counters i = 0 and j = 0, `mem_wren` = 0. If `start` = 1, go to INIT.
- INIT: one cycle per index. Drive `mem_addr` = i, `mem_wdata` = i, `mem_wren` = 1.
  - i increments every cycle.
  - After i = 255, set i = 0 and j = 0, then go to RD_I.
- RD_I: drive `mem_addr` = i, `mem_wren` = 0.
- LAT_I: capture si = `mem_rdata`. Compute j_next = j + si + key[i mod KEY_BYTES], modulo 256 (8-bit wrap), and register it into j.
- RD_J: drive `mem_addr` = j (the updated value), `mem_wren` = 0.
- LAT_J: capture sj = `mem_rdata`.
- WR_I: drive `mem_addr` = i, `mem_wdata` = sj, `mem_wren` = 1.
- WR_J: drive `mem_addr` = j, `mem_wdata` = si, `mem_wren` = 1.
  - If i = 255, go to DONE.
  - Otherwise i = i + 1 and go to RD_I.
- DONE: `done` = 1, `mem_wren` = 0. If `start` = 1, clear i and j and go to INIT (back-to-back key trials). Otherwise remain in DONE.
- The i mod KEY_BYTES term comes from a separate 0..KEY_BYTES-1 counter that wraps in step with i. No divider.
- Case i = j: both reads return the same value and both writes store it, so S is unchanged. This is legal and needs no special handling.
- `start` asserted while busy is ignored.
- In any state where `mem_addr` or `mem_wdata` is not specified, its value is don't-care, but `mem_wren` must be 0.

## Timing

- Reset (`reset_n` = 0 at a clock edge), from any state including mid-INIT or mid-swap:
  - next state IDLE, i = 0, j = 0;
  - `mem_wren` = 0, `busy` = 0, `done` = 0;
  - `mem_addr` = 0, `mem_wdata` = 0.
- A partially permuted S left by a reset is not repaired. The next `start` rebuilds it from INIT.
- Outputs are valid in the cycle of their state. The RAM samples address, data and write enable on the next rising edge.
- Read latency: `mem_rdata` is valid in the cycle immediately after RD_I or RD_J.
- Cycle counts, with edge 0 being the edge that samples `start`:
  - INIT occupies cycles 1–256.
  - The swap loop takes 6 cycles per i, 1536 cycles total, occupying cycles 257–1792.
  - `done` is first high in cycle 1793.
- Total write count per schedule is 256 + 512 = 768.
- `done` stays high until a new start is accepted or reset occurs. It drops in the first INIT cycle.

## Test plan

- Reset, then `start` with `secret_key` = 24'h000000:
  - INIT writes addr 0x00..0xFF with `mem_wdata` equal to the address, on consecutive cycles.
  - i = 0: WR_I writes addr 0 data 0; WR_J writes addr 0 data 0.
  - i = 1: j = 1, self-swap.
  - i = 2: j = 3; writes are addr 2 data 3, then addr 3 data 2.
- Key 24'h000249 and 24'hFFFFFF: final RAM contents match a software RC4 KSA model byte for byte. The final contents form a permutation of 0..255. `done` rises exactly 1793 cycles after the `start` sample.
- Wrap check with key 24'hFFFFFF: j sums exceed 255 and must wrap modulo 256, matching the model.
- Reset mid-run:
  - Deassert `reset_n` at cycle 600: the next cycle shows `busy` = 0 and `mem_wren` = 0, with no further writes.
  - A later `start` yields a correct S for a new key.
- Restart from DONE: pulse `start` with a new key while `done` = 1. `done` drops next cycle, INIT restarts at addr 0, and the final S matches the model.
- Protocol checks:
  - `start` pulses during `busy` have no effect on the write trace.
  - `mem_wren` is never high in IDLE, DONE, RD_*, or LAT_*.
